// File: rtl/bpred_table_sched.sv
// Arbiter for a single-port 2-bit-counter pattern table: IF lookups, queued RoB
// read-modify-write updates, and the post-reset weakly-not-taken init sweep.
//
// state  | meaning
// INIT   | sweep writes 2'b01 to every entry, one per rdy cycle
// IDLE   | one access per cycle: IF lookup, or read of the FIFO head
// UPD_WR | write back the saturated counter for the FIFO head, then pop
module bpred_table_sched #(
  parameter int IDX_W      = 6,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             if_req,
  input  logic [31:0]      if_pc,
  output logic             if_gnt,
  output logic             if_resp_valid,
  output logic             if_tojump,
  input  logic             rob_valid,
  input  logic [31:0]      rob_now_pc,
  input  logic             should_jump,
  output logic             rob_ready,
  output logic             init_busy,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [1:0]       tbl_wdata,
  input  logic [1:0]       tbl_rdata
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_UPD_WR} state_t;

  state_t           state;
  logic [IDX_W-1:0] init_ptr;
  logic [SC_W-1:0]  starve_cnt;
  logic [IDX_W:0]   fifo_mem [QDEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic             fifo_empty, if_ok, push, pop;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;
  logic [1:0]       upd_data;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0],
                            rob_now_pc[31:IDX_W+2], rob_now_pc[1:0]};

  assign fifo_empty = (count == '0);
  assign {head_idx, head_taken} = fifo_mem[rd_ptr];
  assign init_busy  = (state == S_INIT);
  assign rob_ready  = !init_busy && (count < CNT_W'(QDEPTH));
  assign if_ok      = (state == S_IDLE) && if_req &&
                      (fifo_empty || (starve_cnt < SC_W'(STARVE_MAX)));
  assign if_gnt     = rdy_in && if_ok;
  assign push       = rdy_in && rob_valid && rob_ready;
  assign pop        = rdy_in && (state == S_UPD_WR);
  assign if_tojump  = tbl_rdata[1];

  always_comb begin
    upd_data = tbl_rdata;
    if (head_taken) begin
      if (tbl_rdata != 2'b11) upd_data = tbl_rdata + 2'b01;
    end else begin
      if (tbl_rdata != 2'b00) upd_data = tbl_rdata - 2'b01;
    end
  end

  always_comb begin
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = 2'b00;
    case (state)
      S_INIT: begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = init_ptr;
        tbl_wdata = 2'b01;
      end
      S_IDLE: begin
        if (if_ok) begin
          tbl_en   = 1'b1;
          tbl_addr = if_pc[IDX_W+1:2];
        end else if (!fifo_empty) begin
          tbl_en   = 1'b1;
          tbl_addr = head_idx;
        end
      end
      S_UPD_WR: begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = head_idx;
        tbl_wdata = upd_data;
      end
      default: ;
    endcase
    if (!rdy_in) tbl_en = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= S_INIT;
      init_ptr      <= '0;
      starve_cnt    <= '0;
      if_resp_valid <= 1'b0;
    end else if (rdy_in) begin
      if_resp_valid <= if_gnt;
      case (state)
        S_INIT: begin
          init_ptr <= init_ptr + IDX_W'(1);
          if (init_ptr == '1) state <= S_IDLE;
        end
        S_IDLE: begin
          if (if_ok) begin
            // Only lookups that bypass a waiting update count toward starvation.
            if (fifo_empty)
              starve_cnt <= '0;
            else if (starve_cnt != SC_W'(STARVE_MAX))
              starve_cnt <= starve_cnt + SC_W'(1);
          end else if (!fifo_empty) begin
            starve_cnt <= '0;
            state      <= S_UPD_WR;
          end
        end
        S_UPD_WR: state <= S_IDLE;
        default:  state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem[wr_ptr] <= {rob_now_pc[IDX_W+1:2], should_jump};
  end

endmodule

// File: tb/tb_bpred_table_sched.sv
// Directed bench for bpred_table_sched with a behavioural sync SRAM behind
// the table port; expected values are hand-derived from the counter rules.
module tb_bpred_table_sched;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_gnt, if_resp_valid, if_tojump;
  logic        rob_valid = 1'b0;
  logic [31:0] rob_now_pc = '0;
  logic        should_jump = 1'b0;
  logic        rob_ready, init_busy, tbl_en, tbl_we;
  logic [5:0]  tbl_addr;
  logic [1:0]  tbl_wdata;
  logic [1:0]  tbl_rdata = 2'b00;
  logic [1:0]  mem [64];

  int n_vec = 0;
  int n_err = 0;

  bpred_table_sched #(.IDX_W(6), .QDEPTH(4), .STARVE_MAX(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_pc(if_pc), .if_gnt(if_gnt),
    .if_resp_valid(if_resp_valid), .if_tojump(if_tojump),
    .rob_valid(rob_valid), .rob_now_pc(rob_now_pc), .should_jump(should_jump),
    .rob_ready(rob_ready), .init_busy(init_busy),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Single-port sync SRAM: read data appears after the edge and holds otherwise.
  always @(posedge clk_in) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc, input logic exp_tj, input string name);
    logic [5:0] exp_idx;
    exp_idx = pc[7:2];
    if_req = 1'b1;
    if_pc  = pc;
    @(negedge clk_in);
    n_vec++;
    if ({if_gnt, tbl_en, tbl_we, tbl_addr} !== {1'b1, 1'b1, 1'b0, exp_idx}) begin
      n_err++;
      $display("FAIL %s_grant: gnt/en/we/addr=%b/%b/%b/%0d want 1/1/0/%0d",
               name, if_gnt, tbl_en, tbl_we, tbl_addr, exp_idx);
    end
    tick();
    if_req = 1'b0;
    @(negedge clk_in);
    n_vec++;
    if ({if_resp_valid, if_tojump} !== {1'b1, exp_tj}) begin
      n_err++;
      $display("FAIL %s_resp: valid/tojump=%b/%b want 1/%b", name, if_resp_valid, if_tojump, exp_tj);
    end
    tick();
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken, input logic [1:0] exp_w,
                           input string name);
    logic [5:0] exp_idx;
    bit found;
    int k;
    exp_idx     = pc[7:2];
    rob_valid   = 1'b1;
    rob_now_pc  = pc;
    should_jump = taken;
    @(negedge clk_in);
    n_vec++;
    if (rob_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready: rob_ready=%b want 1", name, rob_ready);
    end
    tick();
    rob_valid = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 8) begin
      @(negedge clk_in);
      if (tbl_en && tbl_we) begin
        found = 1'b1;
        n_vec++;
        if ({tbl_addr, tbl_wdata} !== {exp_idx, exp_w}) begin
          n_err++;
          $display("FAIL %s_write: addr/wdata=%0d/%b want %0d/%b", name, tbl_addr, tbl_wdata,
                   exp_idx, exp_w);
        end
      end
      tick();
      k++;
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: no write within 8 cycles, want write %b", name, exp_w);
    end
  endtask

  task automatic test_reset;
    @(negedge clk_in);
    n_vec++;
    if ({tbl_en, tbl_we, tbl_addr, tbl_wdata} !== {1'b1, 1'b1, 6'd0, 2'b01}) begin
      n_err++;
      $display("FAIL reset_tbl: en/we/addr/wdata=%b/%b/%0d/%b want 1/1/0/01",
               tbl_en, tbl_we, tbl_addr, tbl_wdata);
    end
    n_vec++;
    if ({init_busy, rob_ready, if_gnt, if_resp_valid} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_flags: busy/ready/gnt/resp=%b%b%b%b want 1000",
               init_busy, rob_ready, if_gnt, if_resp_valid);
    end
    tick();
    rst_n_in = 1'b1;
  endtask

  task automatic test_init;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_in);
      n_vec++;
      if ({tbl_en, tbl_we, tbl_addr, tbl_wdata, init_busy, if_gnt} !==
          {1'b1, 1'b1, 6'(i), 2'b01, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL init_write%0d: en/we/addr/wdata/busy=%b/%b/%0d/%b/%b want 1/1/%0d/01/1",
                 i, tbl_en, tbl_we, tbl_addr, tbl_wdata, init_busy, i);
      end
      tick();
    end
    @(negedge clk_in);
    n_vec++;
    if ({init_busy, rob_ready, tbl_en} !== 3'b010) begin
      n_err++;
      $display("FAIL init_done: busy/ready/en=%b%b%b want 010", init_busy, rob_ready, tbl_en);
    end
    tick();
    do_lookup(32'h100, 1'b0, "init_lookup");
  endtask

  task automatic test_update_alias;
    do_update(32'h100, 1'b1, 2'b10, "alias_upd1");
    do_update(32'h100, 1'b1, 2'b11, "alias_upd2");
    do_lookup(32'h200, 1'b1, "alias_lookup");
  endtask

  task automatic test_saturation;
    do_update(32'h14, 1'b0, 2'b00, "sat_nt1");
    do_update(32'h14, 1'b0, 2'b00, "sat_nt2");
    do_update(32'h14, 1'b0, 2'b00, "sat_nt3");
    do_lookup(32'h14, 1'b0, "sat_low_lookup");
    do_update(32'h14, 1'b1, 2'b01, "sat_t1");
    do_update(32'h14, 1'b1, 2'b10, "sat_t2");
    do_update(32'h14, 1'b1, 2'b11, "sat_t3");
    do_update(32'h14, 1'b1, 2'b11, "sat_t4");
    do_lookup(32'h14, 1'b1, "sat_high_lookup");
  endtask

  task automatic test_starve;
    logic [6:0] gnt_bits, we_bits, rv_bits;
    if_req      = 1'b1;
    if_pc       = 32'h300;
    rob_valid   = 1'b1;
    rob_now_pc  = 32'h14;
    should_jump = 1'b1;
    @(negedge clk_in);
    n_vec++;
    if ({if_gnt, rob_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL starve_first: gnt/ready=%b%b want 11", if_gnt, rob_ready);
    end
    tick();
    rob_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk_in);
      gnt_bits[6-k] = if_gnt;
      we_bits[6-k]  = tbl_en & tbl_we;
      rv_bits[6-k]  = if_resp_valid;
      tick();
    end
    if_req = 1'b0;
    n_vec++;
    if (gnt_bits !== 7'b1111001) begin
      n_err++;
      $display("FAIL starve_gnt: pattern=%b want 1111001", gnt_bits);
    end
    n_vec++;
    if (we_bits !== 7'b0000010) begin
      n_err++;
      $display("FAIL starve_we: pattern=%b want 0000010", we_bits);
    end
    n_vec++;
    if (rv_bits !== 7'b1111100) begin
      n_err++;
      $display("FAIL starve_resp: pattern=%b want 1111100", rv_bits);
    end
  endtask

  task automatic test_back_to_back_full;
    logic [7:0] wd;
    int nwr;
    if_req = 1'b1;
    if_pc  = 32'h0;
    for (int k = 0; k < 5; k++) begin
      rob_valid   = 1'b1;
      rob_now_pc  = 32'h28;
      should_jump = 1'b1;
      @(negedge clk_in);
      n_vec++;
      if (rob_ready !== (k < 4)) begin
        n_err++;
        $display("FAIL full_ready%0d: rob_ready=%b want %b", k, rob_ready, (k < 4));
      end
      tick();
    end
    rob_valid = 1'b0;
    if_req    = 1'b0;
    wd  = '0;
    nwr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (tbl_en && tbl_we) begin
        wd = {wd[5:0], tbl_wdata};
        nwr++;
      end
      tick();
    end
    n_vec++;
    if (nwr != 4) begin
      n_err++;
      $display("FAIL full_count: writes=%0d want 4", nwr);
    end
    n_vec++;
    if (wd !== 8'b10111111) begin
      n_err++;
      $display("FAIL full_data: wdata seq=%b want 10111111", wd);
    end
    @(negedge clk_in);
    n_vec++;
    if ({rob_ready, tbl_en} !== 2'b10) begin
      n_err++;
      $display("FAIL full_drained: ready/en=%b%b want 10", rob_ready, tbl_en);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bit found;
    int k;
    logic [5:0] exp_addr;
    rob_valid   = 1'b1;
    rob_now_pc  = 32'h14;
    should_jump = 1'b0;
    tick();
    rob_valid = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < 8) begin
      @(negedge clk_in);
      if (tbl_en && tbl_we) found = 1'b1;
      else tick();
      k++;
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL rstmid_upd: no UPD_WR write seen, want one");
    end
    rst_n_in = 1'b0;
    #1;
    n_vec++;
    if ({tbl_en, tbl_we, tbl_addr, tbl_wdata, init_busy, rob_ready} !==
        {1'b1, 1'b1, 6'd0, 2'b01, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL rstmid_out: en/we/addr/wdata/busy/ready=%b/%b/%0d/%b/%b/%b want 1/1/0/01/1/0",
               tbl_en, tbl_we, tbl_addr, tbl_wdata, init_busy, rob_ready);
    end
    tick();
    rst_n_in = 1'b1;
    n_vec++;
    if (mem[5] !== 2'b11) begin
      n_err++;
      $display("FAIL rstmid_abandon: mem[5]=%b want 11", mem[5]);
    end
    for (int i = 0; i < 67; i++) begin
      rdy_in   = (i < 10 || i >= 13);
      exp_addr = (i < 10) ? 6'(i) : 6'(i - 3);
      @(negedge clk_in);
      n_vec++;
      if (rdy_in ? ({tbl_en, tbl_addr, init_busy} !== {1'b1, exp_addr, 1'b1})
                 : ({tbl_en, init_busy} !== 2'b01)) begin
        n_err++;
        $display("FAIL sweep%0d: en/addr/busy=%b/%0d/%b want %b/%0d/1",
                 i, tbl_en, tbl_addr, init_busy, rdy_in, exp_addr);
      end
      tick();
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    n_vec++;
    if ({init_busy, tbl_en} !== 2'b00) begin
      n_err++;
      $display("FAIL sweep_done: busy/en=%b%b want 00", init_busy, tbl_en);
    end
    tick();
    do_lookup(32'h14, 1'b0, "rstmid_lookup");
    rdy_in = 1'b0;
    if_req = 1'b1;
    @(negedge clk_in);
    n_vec++;
    if ({if_gnt, tbl_en} !== 2'b00) begin
      n_err++;
      $display("FAIL rdy_freeze: gnt/en=%b%b want 00", if_gnt, tbl_en);
    end
    tick();
    rdy_in = 1'b1;
    if_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_init();
    test_update_alias();
    test_saturation();
    test_starve();
    test_back_to_back_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want run complete");
    $fatal(1, "watchdog");
  end

endmodule
